dpd_adapt_sched: RTL and testbench
==================================

Name: dpd_adapt_sched

Overview:
Sequencer that generates the dpd_adapt window for the dpd core. It waits for the PA feedback loop delay to settle, then opens adaptation windows of fixed length, separated by a coefficient-apply gap. It runs a programmed number of iterations (single-shot mode) or until stopped (continuous mode). It sits between the control/register layer and the dpd instance's dpd_adapt input, and replaces the free-running counter compare used in the bench.

Parameters:
SETTLE, 540, cycles waited before each window (covers PA loop delay plus pipeline)
WIN_LEN, 801, cycles dpd_adapt is held high per window
GAP_LEN, 1000, cycles after a window for the coefficient update to apply
ITER_W, 8, width of iteration count and counter
CNT_W, $clog2(max(SETTLE,WIN_LEN,GAP_LEN))+1, internal phase counter width (derived; not for override)

Ports:
clk  in  1  system clock
reset_b  in  1  synchronous, active-high reset (name kept per codebase; polarity fixed active-high)
start  in  1  level-sampled request to begin a run; ignored while busy
stop  in  1  forces return to IDLE; overrides start
mode_cont  in  1  1 = continuous, 0 = single-shot; latched on accepted start
num_iter  in  ITER_W  iterations for single-shot; latched on accepted start; 0 treated as 1
magn_pa  in  20  PA feedback magnitude (u20); used only with ADAPT_MAG_GUARD_EN
mag_thr  in  20  guard threshold (u20); used only with ADAPT_MAG_GUARD_EN
dpd_adapt  out  1  adaptation enable to the dpd core
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse on normal completion of a single-shot run
abort  out  1  one-cycle pulse when a window is cut short
iter_cnt  out  ITER_W  completed windows in the current run
state  out  2  IDLE=0, SETTLE=1, ADAPT=2, GAP=3

Behaviour:
- Reset (reset_b=1 at posedge): state=IDLE, all outputs 0, latched mode/num_iter cleared. Reset mid-run drops dpd_adapt on the next edge with no abort or done pulse.
- All outputs are registered. dpd_adapt = (state==ADAPT). busy = (state!=IDLE).
- IDLE: if start=1 and stop=0 at an edge, go to SETTLE. On the same edge: phase counter=0, iter_cnt=0, latch mode_cont and num_iter.
- SETTLE: runs for exactly SETTLE cycles, then goes to ADAPT with counter=0.
- ADAPT: runs for exactly WIN_LEN cycles. On exit, iter_cnt increments.
  - Single-shot with iter_cnt+1 >= latched num_iter: go to IDLE with done=1 on that edge.
  - Otherwise: go to GAP.
- GAP: runs for exactly GAP_LEN cycles, then goes to SETTLE.
- Continuous mode: iter_cnt wraps from 2^ITER_W-1 to 0. done never fires.
- stop=1 in any non-IDLE state: go to IDLE on the next edge.
  - If stopped from ADAPT: abort=1 on that edge; iter_cnt not incremented.
  - If stopped from SETTLE or GAP: no pulse.
  - iter_cnt holds its value in IDLE until the next accepted start.
- start and stop high together in IDLE: no action.
- start while busy: ignored; latched values unchanged.
- Changes to mode_cont or num_iter mid-run: no effect.
- Latency: start accepted at edge 0 → dpd_adapt high in cycles 541..1341 with defaults.
- Counters compare with ==; they never exceed their phase length.

Optional Feature:
ADAPT_MAG_GUARD_EN: when defined, if magn_pa > mag_thr (unsigned) on any ADAPT cycle, the next edge forces state=GAP and abort=1. iter_cnt is not incremented; the window is retried after GAP+SETTLE. stop takes priority over the guard. When undefined, magn_pa and mag_thr are ignored (ports remain) and abort arises only from stop.

Test Plan:
1. Hold reset_b=1 for 4 cycles with start=1 → state=0; dpd_adapt, busy, done, abort, iter_cnt all 0; no start accepted during reset.
2. Single-shot, num_iter=1, start at edge 0 → dpd_adapt high exactly cycles 541..1341 (801 cycles); done=1 and busy=0 at cycle 1342; iter_cnt=1.
3. Single-shot, num_iter=3 → windows start at 541, 2882, 5223 (period 2341); done at 6024; iter_cnt=3. num_iter=0 behaves as 1.
4. Continuous run, stop pulsed at cycle 800 → dpd_adapt=0 and abort=1 at cycle 801, state=IDLE, iter_cnt=0, no done. stop during GAP gives no abort.
5. start+stop same cycle in IDLE → stays IDLE. start pulse at cycle 300 of a run → ignored, timing unchanged.
6. With ADAPT_MAG_GUARD_EN, mag_thr=500000, magn_pa=600000 at cycle 600 → abort at 601, GAP 601..1600, SETTLE 1601..2140, retry window from 2141. Without the macro → window completes normally.

Source files
------------

// File: rtl/dpd_adapt_sched.sv
// Adaptation-window sequencer for the dpd core: SETTLE -> ADAPT -> GAP -> SETTLE ...
// Optional magnitude guard on the ADAPT window enabled by defining ADAPT_MAG_GUARD_EN.
module dpd_adapt_sched #(
    parameter int unsigned SETTLE  = 540,
    parameter int unsigned WIN_LEN = 801,
    parameter int unsigned GAP_LEN = 1000,
    parameter int unsigned ITER_W  = 8
) (
    input  logic              clk,
    input  logic              reset_b,
    input  logic              start,
    input  logic              stop,
    input  logic              mode_cont,
    input  logic [ITER_W-1:0] num_iter,
    input  logic [19:0]       magn_pa,
    input  logic [19:0]       mag_thr,
    output logic              dpd_adapt,
    output logic              busy,
    output logic              done,
    output logic              abort,
    output logic [ITER_W-1:0] iter_cnt,
    output logic [1:0]        state
);

    localparam int unsigned MAX_SW  = (SETTLE > WIN_LEN) ? SETTLE : WIN_LEN;
    localparam int unsigned MAX_LEN = (MAX_SW > GAP_LEN) ? MAX_SW : GAP_LEN;
    localparam int unsigned CNT_W   = $clog2(MAX_LEN) + 1;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StSettle = 2'd1,
        StAdapt  = 2'd2,
        StGap    = 2'd3
    } state_e;

    state_e              r_state, w_state_d;
    logic [CNT_W-1:0]    r_cnt, w_cnt_d;
    logic [ITER_W-1:0]   r_iter, w_iter_d;
    logic [ITER_W-1:0]   r_num, w_num_d;
    logic                r_mode, w_mode_d;
    logic                r_done, w_done_d;
    logic                r_abort, w_abort_d;
    logic                r_adapt, r_busy;
    logic [ITER_W-1:0]   w_num_eff;
    logic                w_last_iter;
    logic                w_guard_trip;

    // num_iter of 0 runs a single window
    assign w_num_eff   = (r_num == '0) ? ITER_W'(1) : r_num;
    assign w_last_iter = ({1'b0, r_iter} + (ITER_W + 1)'(1)) >= {1'b0, w_num_eff};

`ifdef ADAPT_MAG_GUARD_EN
    assign w_guard_trip = (magn_pa > mag_thr);
`else
    logic w_unused;
    assign w_unused     = ^{magn_pa, mag_thr};
    assign w_guard_trip = 1'b0;
`endif

    always_comb begin
        w_state_d = r_state;
        w_cnt_d   = r_cnt;
        w_iter_d  = r_iter;
        w_num_d   = r_num;
        w_mode_d  = r_mode;
        w_done_d  = 1'b0;
        w_abort_d = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (start && !stop) begin
                    w_state_d = StSettle;
                    w_cnt_d   = '0;
                    w_iter_d  = '0;
                    w_mode_d  = mode_cont;
                    w_num_d   = num_iter;
                end
            end
            StSettle: begin
                if (stop) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_W'(SETTLE - 1)) begin
                    w_state_d = StAdapt;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StAdapt: begin
                if (stop) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                    w_abort_d = 1'b1;
                end else if (w_guard_trip) begin
                    // window discarded; retried after the usual GAP and SETTLE
                    w_state_d = StGap;
                    w_cnt_d   = '0;
                    w_abort_d = 1'b1;
                end else if (r_cnt == CNT_W'(WIN_LEN - 1)) begin
                    w_iter_d = r_iter + ITER_W'(1);
                    w_cnt_d  = '0;
                    if (!r_mode && w_last_iter) begin
                        w_state_d = StIdle;
                        w_done_d  = 1'b1;
                    end else begin
                        w_state_d = StGap;
                    end
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            StGap: begin
                if (stop) begin
                    w_state_d = StIdle;
                    w_cnt_d   = '0;
                end else if (r_cnt == CNT_W'(GAP_LEN - 1)) begin
                    w_state_d = StSettle;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset_b) begin
            r_state <= StIdle;
            r_cnt   <= '0;
            r_iter  <= '0;
            r_num   <= '0;
            r_mode  <= 1'b0;
            r_done  <= 1'b0;
            r_abort <= 1'b0;
            r_adapt <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_iter  <= w_iter_d;
            r_num   <= w_num_d;
            r_mode  <= w_mode_d;
            r_done  <= w_done_d;
            r_abort <= w_abort_d;
            r_adapt <= (w_state_d == StAdapt);
            r_busy  <= (w_state_d != StIdle);
        end
    end

    assign dpd_adapt = r_adapt;
    assign busy      = r_busy;
    assign done      = r_done;
    assign abort     = r_abort;
    assign iter_cnt  = r_iter;
    assign state     = r_state;

endmodule

// File: tb/tb_dpd_adapt_sched.sv
// Self-checking bench for dpd_adapt_sched: vector tables, hand sequences and a
// schedule model driven by randomized runs. Define ADAPT_MAG_GUARD_EN for the guard build.
module tb_dpd_adapt_sched;

    localparam int SET = 540;
    localparam int WIN = 801;
    localparam int GAP = 1000;
    localparam int PER = WIN + GAP + SET;

    logic        clk = 1'b0;
    logic        reset_b, start, stop, mode_cont;
    logic [7:0]  num_iter;
    logic [19:0] magn_pa, mag_thr;
    logic        dpd_adapt, busy, done, abort;
    logic [7:0]  iter_cnt;
    logic [1:0]  state;
    logic [13:0] outs;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string      name;
        int         cyc;
        logic [13:0] exp;
    } vec_t;
    vec_t tbl[$];

    dpd_adapt_sched dut (
        .clk       (clk),
        .reset_b   (reset_b),
        .start     (start),
        .stop      (stop),
        .mode_cont (mode_cont),
        .num_iter  (num_iter),
        .magn_pa   (magn_pa),
        .mag_thr   (mag_thr),
        .dpd_adapt (dpd_adapt),
        .busy      (busy),
        .done      (done),
        .abort     (abort),
        .iter_cnt  (iter_cnt),
        .state     (state)
    );

    always #5 clk = ~clk;
    assign outs = {state, dpd_adapt, busy, done, abort, iter_cnt};

    function automatic logic [13:0] pack(int st, bit dn, bit ab, int it);
        logic [1:0] s2 = st[1:0];
        logic [7:0] i8 = it[7:0];
        return {s2, (st == 2), (st != 0), dn, ab, i8};
    endfunction

    // Uninterrupted schedule, c = cycles after the accepting edge (first is 1).
    function automatic logic [13:0] sched(int c, bit cont, int n);
        int neff = (n == 0) ? 1 : n;
        int p, k, r, fin;
        if (c - 1 < SET) return pack(1, 0, 0, 0);
        p   = c - 1 - SET;
        fin = (neff - 1) * PER + WIN;
        if (!cont && p >= fin) return pack(0, (p == fin), 0, neff);
        k = p / PER;
        r = p % PER;
        if (r < WIN) return pack(2, 0, 0, k % 256);
        if (r < WIN + GAP) return pack(3, 0, 0, (k + 1) % 256);
        return pack(1, 0, 0, (k + 1) % 256);
    endfunction

    function automatic logic [13:0] model(int c, bit cont, int n, int stop_at);
        logic [13:0] s;
        if (stop_at > 0 && c > stop_at) begin
            s = sched(stop_at, cont, n);
            if (s[13:12] == 2'd0) return sched(c, cont, n);
            return pack(0, 0, (c == stop_at + 1) && (s[13:12] == 2'd2), s[7:0]);
        end
        return sched(c, cont, n);
    endfunction

    function automatic void add(string nm, int cyc, int st, bit dn, bit ab, int it);
        vec_t v;
        v.name = nm;
        v.cyc  = cyc;
        v.exp  = pack(st, dn, ab, it);
        tbl.push_back(v);
    endfunction

    task automatic chk(input string nm, input int c, input logic [13:0] exp);
        checks++;
        if (outs !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: got st=%0d adapt=%b busy=%b done=%b abort=%b iter=%0d, expected st=%0d adapt=%b busy=%b done=%b abort=%b iter=%0d",
                     nm, c, outs[13:12], outs[11], outs[10], outs[9], outs[8], outs[7:0],
                     exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_run(input string nm, input bit cont, input int n, input int stop_at,
                          input int pulse_at, input int mag_at, input int len,
                          input bit use_model);
        logic [13:0] e;
        mode_cont = cont;
        num_iter  = n[7:0];
        start     = 1'b1;
        stop      = 1'b0;
        tick();
        start = 1'b0;
        for (int c = 1; c <= len; c++) begin
            e = model(c, cont, n, stop_at);
            if (use_model) chk(nm, c, e);
            foreach (tbl[i]) if (tbl[i].cyc == c) chk(tbl[i].name, c, tbl[i].exp);
            stop  = (c == stop_at);
            start = (c == pulse_at) || (use_model && e[13:12] != 2'd0 && $urandom_range(0, 63) == 0);
            if (use_model) begin
                mode_cont = 1'($urandom);
                num_iter  = 8'($urandom);
            end
`ifdef ADAPT_MAG_GUARD_EN
            magn_pa = (c == mag_at) ? 20'd600000 : 20'd0;
`else
            magn_pa = (c == mag_at) ? 20'd600000 : 20'($urandom);
`endif
            tick();
        end
        start   = 1'b0;
        stop    = 1'b0;
        magn_pa = '0;
        tbl.delete();
        if (busy) begin
            stop = 1'b1;
            tick();
            stop = 1'b0;
        end
        tick();
    endtask

    initial begin
        int cont, n, neff, stop_at, fin, len;
        reset_b   = 1'b1;
        start     = 1'b1;
        stop      = 1'b0;
        mode_cont = 1'b0;
        num_iter  = 8'd1;
        magn_pa   = '0;
        mag_thr   = 20'd500000;

        // Reset held with start asserted
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("reset_hold", i, 14'd0);
        end
        start   = 1'b0;
        reset_b = 1'b0;
        tick();
        chk("reset_release", 0, 14'd0);

        // Single-shot, one window
        add("t2_settle_end", 540, 1, 0, 0, 0);
        add("t2_win_first", 541, 2, 0, 0, 0);
        add("t2_win_last", 1341, 2, 0, 0, 0);
        add("t2_done", 1342, 0, 1, 0, 1);
        add("t2_after", 1343, 0, 0, 0, 1);
        do_run("t2_model", 0, 1, 0, 0, 0, 1345, 1);

        // Single-shot, three windows
        add("t3_settle2_end", 2881, 1, 0, 0, 1);
        add("t3_win2", 2882, 2, 0, 0, 1);
        add("t3_settle3_end", 5222, 1, 0, 0, 2);
        add("t3_win3", 5223, 2, 0, 0, 2);
        add("t3_win3_last", 6023, 2, 0, 0, 2);
        add("t3_done", 6024, 0, 1, 0, 3);
        do_run("t3_model", 0, 3, 0, 0, 0, 6026, 1);

        add("t3_n0_done", 1342, 0, 1, 0, 1);
        do_run("t3_n0_model", 0, 0, 0, 0, 0, 1344, 1);

        // Stop from ADAPT and from GAP
        add("t4_adapt", 800, 2, 0, 0, 0);
        add("t4_abort", 801, 0, 0, 1, 0);
        add("t4_after", 802, 0, 0, 0, 0);
        do_run("t4_model", 1, 0, 800, 0, 0, 805, 1);
        add("t4_gap_stop", 1501, 0, 0, 0, 1);
        do_run("t4_gap_model", 0, 2, 1500, 0, 0, 1505, 1);

        // start+stop together in IDLE
        start = 1'b1;
        stop  = 1'b1;
        tick();
        start = 1'b0;
        stop  = 1'b0;
        chk("t5_start_stop", 0, pack(0, 0, 0, 1));
        tick();
        chk("t5_still_idle", 1, pack(0, 0, 0, 1));

        // start pulse while busy is ignored
        add("t5_pulse_win", 541, 2, 0, 0, 0);
        add("t5_pulse_done", 1342, 0, 1, 0, 1);
        do_run("t5_model", 0, 1, 0, 300, 0, 1345, 1);

        // Reset in the middle of a window
        mode_cont = 1'b0;
        num_iter  = 8'd2;
        start     = 1'b1;
        tick();
        start = 1'b0;
        repeat (599) tick();
        chk("midreset_pre", 600, pack(2, 0, 0, 0));
        reset_b = 1'b1;
        tick();
        chk("midreset", 601, 14'd0);
        reset_b = 1'b0;
        tick();
        chk("midreset_idle", 602, 14'd0);

        // Magnitude guard
`ifdef ADAPT_MAG_GUARD_EN
        add("t6_guard_abort", 601, 3, 0, 1, 0);
        add("t6_gap_last", 1600, 3, 0, 0, 0);
        add("t6_settle", 1601, 1, 0, 0, 0);
        add("t6_settle_last", 2140, 1, 0, 0, 0);
        add("t6_retry", 2141, 2, 0, 0, 0);
        add("t6_retry_last", 2941, 2, 0, 0, 0);
        add("t6_done", 2942, 0, 1, 0, 1);
        do_run("t6", 0, 1, 0, 0, 600, 2944, 0);
`else
        add("t6_no_guard", 601, 2, 0, 0, 0);
        add("t6_no_guard_done", 1342, 0, 1, 0, 1);
        do_run("t6_model", 0, 1, 0, 0, 600, 1344, 1);
`endif

        // Randomized runs against the schedule model
        for (int r = 0; r < 6; r++) begin
            cont = int'($urandom_range(0, 1));
            n    = int'($urandom_range(0, 3));
            neff = (n == 0) ? 1 : n;
            fin  = 1342 + (neff - 1) * PER;
            if (cont != 0) begin
                stop_at = int'($urandom_range(1, 2 * PER + 600));
                len     = stop_at + 3;
            end else begin
                stop_at = ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, fin)) : 0;
                len     = fin + 3;
            end
            do_run("rand_model", cont[0], n, stop_at, 0, 0, len, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
